// File: rtl/set_assoc_data_cache_pkg.sv
// Shared types and default widths for the set-associative data cache.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W   = 15;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_OFFSET_W = 2;
    localparam int unsigned DEF_INDEX_W  = 8;
    localparam int unsigned DEF_WAYS     = 2;
    localparam int unsigned DEF_CNT_W    = 16;

    // Way-select width; a direct-mapped cache still carries a 1-bit (constant 0) selector.
    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int unsigned TAG_W = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int unsigned WAY_W = way_bits(DEF_WAYS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } line_t;

endpackage

// File: rtl/set_assoc_data_cache_if.sv
// Request/response and refill-burst signals between driver, cache and memory.
interface set_assoc_data_cache_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W
);
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDR_W-1:0]          address;
    logic                       resp_valid;
    logic [DATA_W-1:0]          outData;
    logic                       resp_hit;
    logic                       mem_req;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr;
    logic                       mem_valid;
    logic [DATA_W-1:0]          mem_data;

    modport slave (
        input  req_valid, address, mem_valid, mem_data,
        output req_ready, resp_valid, outData, resp_hit, mem_req, mem_addr
    );

    modport master (
        output req_valid, address, mem_valid, mem_data,
        input  req_ready, resp_valid, outData, resp_hit, mem_req, mem_addr
    );
endinterface

// File: rtl/set_assoc_data_cache_way_array.sv
// One cache way: per-set valid bit and tag, plus block data written one beat at a time.
module cache_way_array #(
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic                wr_last,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [TAG_W-1:0]    wr_tag
);
    localparam int unsigned SETS  = 1 << INDEX_W;
    localparam int unsigned WORDS = SETS << OFFSET_W;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [WORDS];

    // A line only becomes valid once its final beat lands, so aborted refills stay invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_last) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Beat data and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
        if (wr_en && wr_last) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/set_assoc_data_cache.sv
// N-way set-associative read-only cache with block refill and saturating hit/miss counters.
module set_assoc_data_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W,
    parameter int unsigned INDEX_W  = DEF_INDEX_W,
    parameter int unsigned WAYS     = DEF_WAYS,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    set_assoc_data_cache_if.slave bus,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      hitNum,
    output logic [CNT_W-1:0]      missNum
);
    localparam int unsigned TAG_BITS = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WAY_BITS = way_bits(WAYS);
    localparam int unsigned SETS     = 1 << INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [WAY_BITS-1:0]        victim_q, victim_d;
    logic [OFFSET_W-1:0]        beat_q, beat_d;
    logic                       req_ready_q, req_ready_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic                       mem_req_q, mem_req_d;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]           hit_q, hit_d, miss_q, miss_d;
    logic [SETS-1:0][WAY_BITS-1:0] ptr_q;
    logic [WAY_BITS-1:0]        ptr_next;

    logic                wr_en, wr_last, ptr_adv, count_hit, count_miss, hit_any;
    logic [WAY_BITS-1:0] hit_way, victim;
    logic [TAG_BITS-1:0] req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic [WAYS-1:0]     way_valid, way_wr;
    logic [TAG_BITS-1:0] way_tag  [WAYS];
    logic [DATA_W-1:0]   way_data [WAYS];

    assign req_tag    = addr_q[ADDR_W-1 -: TAG_BITS];
    assign req_index  = addr_q[OFFSET_W +: INDEX_W];
    assign req_offset = addr_q[OFFSET_W-1:0];
    assign wr_last    = (beat_q == LAST_BEAT);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_wr[w] = wr_en && (victim_q == WAY_BITS'(w));
        cache_way_array #(
            .TAG_W(TAG_BITS), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)
        ) u_way (
            .clk(clk), .rst(rst),
            .rd_index(req_index), .rd_offset(req_offset),
            .rd_valid(way_valid[w]), .rd_tag(way_tag[w]), .rd_data(way_data[w]),
            .wr_en(way_wr[w]), .wr_last(wr_last), .wr_index(req_index),
            .wr_offset(beat_q), .wr_data(bus.mem_data), .wr_tag(req_tag)
        );
    end

    // Tag match across ways and victim pick: lowest invalid way, else the set pointer.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        victim  = ptr_q[req_index];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tag[w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!way_valid[w]) begin
                victim = WAY_BITS'(w);
            end
        end
        ptr_next = (WAYS == 1) ? '0 : WAY_BITS'(ptr_q[req_index] + 1'b1);
    end

    // Round-robin pointer moves only when a valid line is evicted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (ptr_adv) begin
            ptr_q[req_index] <= ptr_next;
        end
    end

    // Next-state and registered-output values for the lookup/refill controller.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        beat_d       = beat_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        out_data_d   = out_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        wr_en        = 1'b0;
        ptr_adv      = 1'b0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.address;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    count_hit    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    out_data_d   = way_data[hit_way];
                    state_d      = RESPOND;
                end else begin
                    count_miss = 1'b1;
                    victim_d   = victim;
                    ptr_adv    = &way_valid;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q[ADDR_W-1:OFFSET_W];
                    beat_d     = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_valid) begin
                    wr_en     = 1'b1;
                    mem_req_d = 1'b0;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == req_offset) begin
                        out_data_d = bus.mem_data;
                    end
                    if (wr_last) begin
                        resp_valid_d = 1'b1;
                        resp_hit_d   = 1'b0;
                        state_d      = RESPOND;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Saturating statistics; a clear overrides a same-cycle increment.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (count_hit && (hit_q != '1)) begin
            hit_d = hit_q + 1'b1;
        end
        if (count_miss && (miss_q != '1)) begin
            miss_d = miss_q + 1'b1;
        end
        if (clr_stats) begin
            hit_d  = '0;
            miss_d = '0;
        end
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            out_data_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            out_data_q   <= out_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.outData    = out_data_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign hitNum         = hit_q;
    assign missNum        = miss_q;

endmodule
